// File: rtl/apb_master_arb.sv
// Round-robin APB3 master: arbitrates NUM_REQ requesters onto one bus, one transfer in flight.
// Optional ACCESS-phase timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | bus idle, arbitrating among req_valid
// ST_SETUP  | PSEL=1, PENABLE=0 for one cycle
// ST_ACCESS | PSEL=1, PENABLE=1, waiting for PREADY (or timeout)
// ST_DONE   | bus released, req_ready pulse to the winner
module apb_master_arb #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d, win_q, win_d, arb_idx;
  logic                    arb_found, xfer_end;
  int                      cand;
  logic                    psel_d, penable_d, pwrite_d, err_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_d, rdata_d;
  logic [NUM_REQ-1:0]      ready_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!arb_found && req_valid[IDX_W'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    psel_d    = PSEL;
    penable_d = PENABLE;
    pwrite_d  = PWRITE;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;
    ready_d   = '0;
    rdata_d   = rsp_rdata;
    err_d     = rsp_err;
    xfer_end  = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (arb_found) begin
          state_d  = ST_SETUP;
          win_d    = arb_idx;
          psel_d   = 1'b1;
          pwrite_d = req_write[arb_idx];
          paddr_d  = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_d    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          xfer_end = 1'b1;
          err_d    = PSLVERR;
          if (!PWRITE) rdata_d = PRDATA;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == '0) begin
          xfer_end = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (xfer_end) begin
      state_d   = ST_DONE;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      ready_d   = NUM_REQ'(1) << win_q;
      ptr_d     = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      req_ready <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      req_ready <= ready_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: vector table of single transfers plus round-robin,
// async reset and (with APB_MASTER_TIMEOUT_EN) timeout sequences.
module tb_apb_master_arb;

  logic        PCLK, PRESETn;
  logic [1:0]  req_valid, req_write, req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, PWDATA, PRDATA;
  logic        rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [4:0]  PADDR;

  int checks = 0;
  int failures = 0;

  // Simple slave: memory with programmable wait states and error injection
  logic [31:0] mem [32];
  int          acc_cnt = 0;
  int          wait_states;
  logic        err_inject;

  assign PREADY  = PSEL && PENABLE && (acc_cnt >= wait_states);
  assign PSLVERR = PREADY && err_inject;
  assign PRDATA  = mem[PADDR];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  apb_master_arb #(.NUM_REQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          r;
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    int          sw;
    logic        se;
    int          exp_acc;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  // Starts and ends at an IDLE-cycle negedge
  task automatic do_xfer(input string name, input int r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input int sw, input logic se, input int exp_acc,
                         input logic [31:0] exp_rd, input logic exp_er);
    int   n, acc;
    logic stable, seen;
    logic [1:0] exp_rdy;
    exp_rdy = 2'(1 << r);
    req_write[r] = w;
    req_addr[r*5 +: 5] = a;
    req_wdata[r*32 +: 32] = d;
    wait_states = sw;
    err_inject = se;
    req_valid[r] = 1'b1;
    n = 0; acc = 0; stable = 1'b1; seen = 1'b0;
    while (!seen && n < 64) begin
      @(posedge PCLK); @(negedge PCLK);
      n++;
      if (n == 1) chk({name, "_setup"}, {PSEL, PENABLE}, 2'b10);
      if (PSEL && PENABLE) begin
        acc++;
        if (PADDR !== a || PWRITE !== w || (w && PWDATA !== d)) stable = 1'b0;
      end
      if (req_ready != 2'b00) seen = 1'b1;
    end
    chk({name, "_latency"}, n, exp_acc + 2);
    chk({name, "_access_cycles"}, acc, exp_acc);
    chk({name, "_stable"}, stable, 1'b1);
    chk({name, "_ready"}, req_ready, exp_rdy);
    chk({name, "_rdata"}, rsp_rdata, exp_rd);
    chk({name, "_err"}, rsp_err, exp_er);
    chk({name, "_done_bus"}, {PSEL, PENABLE}, 2'b00);
    req_valid[r] = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    chk({name, "_ready_pulse"}, req_ready, 2'b00);
  endtask

  vec_t vecs[7];
  logic [15:0] trace;
  logic [7:0]  order;
  int g0, g1, n;

  initial begin
    vecs[0] = '{0, 1'b1, 5'h04, 32'hDEADBEEF, 0, 1'b0, 1, 32'h0,        1'b0};
    vecs[1] = '{1, 1'b0, 5'h04, 32'h0,        0, 1'b0, 1, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{0, 1'b1, 5'h1F, 32'h12345678, 3, 1'b1, 4, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{1, 1'b0, 5'h1F, 32'h0,        0, 1'b0, 1, 32'h12345678, 1'b0};
    vecs[4] = '{0, 1'b0, 5'h04, 32'h0,        1, 1'b0, 2, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{1, 1'b1, 5'h10, 32'hA5A5A5A5, 2, 1'b0, 3, 32'hDEADBEEF, 1'b0};
    vecs[6] = '{1, 1'b0, 5'h10, 32'h0,        0, 1'b0, 1, 32'hA5A5A5A5, 1'b0};

    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    wait_states = 0; err_inject = 1'b0;
    #1;
    chk("reset_ctrl", {req_ready, rsp_err, PSEL, PENABLE, PWRITE, PADDR}, 64'h0);
    chk("reset_data", {rsp_rdata, PWDATA}, 64'h0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    for (int i = 0; i < 7; i++)
      do_xfer($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].sw,
              vecs[i].se, vecs[i].exp_acc, vecs[i].exp_rd, vecs[i].exp_er);

    // Round robin with both requesters holding two transfers each
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    req_write = 2'b11; req_addr = {5'h02, 5'h01}; req_wdata = {32'h22, 32'h11};
    wait_states = 0; err_inject = 1'b0;
    req_valid = 2'b11;
    trace = '0; order = '0; g0 = 0; g1 = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge PCLK); @(negedge PCLK);
      trace = {trace[14:0], PSEL};
      if (req_ready != 2'b00) begin
        order = {order[5:0], req_ready};
        if (req_ready[0]) begin g0++; if (g0 == 2) req_valid[0] = 1'b0; end
        if (req_ready[1]) begin g1++; if (g1 == 2) req_valid[1] = 1'b0; end
      end
    end
    chk("rr_order", order, 8'b01_10_01_10);
    chk("rr_psel_trace", trace, 16'b1100_1100_1100_1100);

    // Async reset during a stalled ACCESS phase
    req_write = 2'b01; req_addr = {5'h10, 5'h07}; req_wdata = {32'h0, 32'h77};
    wait_states = 1000;
    req_valid = 2'b01;
    @(posedge PCLK); @(negedge PCLK);
    @(posedge PCLK); @(negedge PCLK);
    chk("rst_in_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1 chk("rst_immediate", {PSEL, PENABLE, req_ready}, 4'b0);
    repeat (2) @(negedge PCLK);
    chk("rst_no_ready", {PSEL, req_ready}, 3'b0);
    PRESETn = 1'b1;
    wait_states = 0;
    req_valid = 2'b11;
    n = 0;
    do begin @(posedge PCLK); @(negedge PCLK); n++; end while (req_ready == 2'b00 && n < 20);
    chk("rst_first_grant", req_ready, 2'b01);
    chk("rst_first_latency", n, 3);
    req_valid[0] = 1'b0;
    n = 0;
    do begin @(posedge PCLK); @(negedge PCLK); n++; end while (req_ready == 2'b00 && n < 20);
    chk("rst_second_grant", req_ready, 2'b10);
    chk("rst_second_rdata", rsp_rdata, 32'hA5A5A5A5);
    req_valid[1] = 1'b0;
    @(posedge PCLK); @(negedge PCLK);

`ifdef APB_MASTER_TIMEOUT_EN
    do_xfer("timeout", 1, 1'b0, 5'h03, 32'h0, 1000, 1'b0, 8, 32'hA5A5A5A5, 1'b1);
    do_xfer("after_timeout", 0, 1'b0, 5'h10, 32'h0, 0, 1'b0, 1, 32'hA5A5A5A5, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
